ether_fcs_append: RTL and testbench

- Sits directly downstream of ethernet_tx on the 4-bit (nibble, MII-style) transmit path.
- Passes the preamble, SFD, header and payload stream through unchanged.
- Zero-pads short frames to the Ethernet minimum, computes the CRC32 and appends the 8-nibble FCS.
- Enforces the inter-frame gap before a new frame is accepted; its output feeds the PHY/MII transmit pins.

---
 rtl/ether_fcs_append.sv | 190 +++++++++++++++++++
 tb/tb_ether_fcs_append.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ether_fcs_append.sv
// ether_fcs_append
// ----------------
// Nibble-wide (MII-style) Ethernet transmit stage placed after ethernet_tx.
// Forwards preamble/SFD/header/payload unchanged with one cycle of latency,
// zero-pads short frames up to MIN_NIBBLES post-SFD nibbles, appends the
// 8-nibble FCS (CRC32, reflected) and then holds the line idle for
// IFG_CYCLES cycles before accepting the next frame.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst    in   1  asynchronous, active-high reset
//   axiid  in   4  input nibble, low nibble of each byte first
//   axiiv  in   1  axiid valid; one contiguous high run is one frame
//   axiir  out  1  ready; high only in IDLE, PREAMBLE and DATA
//   axiod  out  4  output nibble (registered)
//   axiov  out  1  axiod valid (registered)
//   err    out  1  one-cycle pulse: axiiv was high while axiir was low
module ether_fcs_append #(
    parameter int PREAMBLE_NIBBLES = 16,
    parameter int MIN_NIBBLES      = 120,
    parameter int IFG_CYCLES       = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] axiid,
    input  logic       axiiv,
    output logic       axiir,
    output logic [3:0] axiod,
    output logic       axiov,
    output logic       err
);

    localparam int PW = (PREAMBLE_NIBBLES > 1) ? $clog2(PREAMBLE_NIBBLES + 1) : 1;
    localparam int DW = (MIN_NIBBLES > 0)      ? $clog2(MIN_NIBBLES + 1)      : 1;
    localparam int IW = (IFG_CYCLES > 1)       ? $clog2(IFG_CYCLES + 1)       : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_NIBBLES - 1);
    localparam logic [DW-1:0] MIN_CNT  = DW'(MIN_NIBBLES);
    localparam logic [IW-1:0] IFG_LAST = IW'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_PAD,
        S_FCS,
        S_IFG
    } state_t;

    state_t          r_state;
    logic [31:0]     r_crc;
    logic [PW-1:0]   r_pre_cnt;
    logic [DW-1:0]   r_data_cnt;
    logic [2:0]      r_fcs_idx;
    logic [IW-1:0]   r_ifg_cnt;
    logic [3:0]      r_axiod;
    logic            r_axiov;
    logic            r_axiir;
    logic            r_err;

    // Four serial steps of the reflected CRC32, nibble bit 0 first.
    function automatic logic [31:0] crc32_nibble(input logic [31:0] crc, input logic [3:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 4; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    logic [31:0]   w_crc_data;
    logic [31:0]   w_crc_pad;
    logic [31:0]   w_crc_inv;
    logic [3:0]    w_fcs_nib;
    logic [DW-1:0] w_data_inc;
    logic          w_data_end;
    logic          w_do_pad;
    logic          w_do_fcs;

    assign w_crc_data = crc32_nibble(r_crc, axiid);
    assign w_crc_pad  = crc32_nibble(r_crc, 4'h0);
    assign w_crc_inv  = ~r_crc;
    assign w_fcs_nib  = w_crc_inv[{r_fcs_idx, 2'b00} +: 4];
    assign w_data_inc = r_data_cnt + DW'(1);

    // The cycle in which axiiv falls in DATA already emits the first pad or
    // FCS nibble, so the output stays contiguous with the last data nibble.
    assign w_data_end = (r_state == S_DATA) && !axiiv;
    assign w_do_pad   = (r_state == S_PAD) || (w_data_end && (r_data_cnt != MIN_CNT));
    assign w_do_fcs   = (r_state == S_FCS) || (w_data_end && (r_data_cnt == MIN_CNT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_crc      <= 32'hFFFF_FFFF;
            r_pre_cnt  <= '0;
            r_data_cnt <= '0;
            r_fcs_idx  <= '0;
            r_ifg_cnt  <= '0;
            r_axiod    <= 4'h0;
            r_axiov    <= 1'b0;
            r_axiir    <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only; the defaults below are
            // overridden by later assignments in this block, so the last
            // assignment in program order wins for that clock edge.
            r_err   <= axiiv && !r_axiir;
            r_axiov <= 1'b0;
            r_axiod <= 4'h0;

            case (r_state)
                S_IDLE: begin
                    if (axiiv) begin
                        r_axiov    <= 1'b1;
                        r_axiod    <= axiid;
                        r_pre_cnt  <= PW'(1);
                        r_data_cnt <= '0;
                        r_fcs_idx  <= '0;
                        r_crc      <= 32'hFFFF_FFFF;
                        r_state    <= (PREAMBLE_NIBBLES > 1) ? S_PREAMBLE : S_DATA;
                    end
                end

                S_PREAMBLE: begin
                    if (axiiv) begin
                        r_axiov   <= 1'b1;
                        r_axiod   <= axiid;
                        r_pre_cnt <= r_pre_cnt + PW'(1);
                        if (r_pre_cnt == PRE_LAST) r_state <= S_DATA;
                    end else begin
                        // Aborted preamble: this idle cycle is the first of the gap.
                        r_ifg_cnt <= IW'(1);
                        r_state   <= (IFG_CYCLES > 1) ? S_IFG : S_IDLE;
                        r_axiir   <= !(IFG_CYCLES > 1);
                    end
                end

                S_DATA: begin
                    if (axiiv) begin
                        r_axiov <= 1'b1;
                        r_axiod <= axiid;
                        r_crc   <= w_crc_data;
                        if (r_data_cnt != MIN_CNT) r_data_cnt <= w_data_inc;
                    end else begin
                        r_axiir <= 1'b0;
                    end
                end

                S_IFG: begin
                    if (r_ifg_cnt == IFG_LAST) begin
                        r_state <= S_IDLE;
                        r_axiir <= 1'b1;
                    end else begin
                        r_ifg_cnt <= r_ifg_cnt + IW'(1);
                    end
                end

                default: ;
            endcase

            if (w_do_pad) begin
                r_axiov    <= 1'b1;
                r_axiod    <= 4'h0;
                r_crc      <= w_crc_pad;
                r_data_cnt <= w_data_inc;
                r_state    <= (w_data_inc == MIN_CNT) ? S_FCS : S_PAD;
            end

            if (w_do_fcs) begin
                r_axiov   <= 1'b1;
                r_axiod   <= w_fcs_nib;
                r_fcs_idx <= r_fcs_idx + 3'd1;
                if (r_fcs_idx == 3'd7) begin
                    r_ifg_cnt <= '0;
                    r_state   <= S_IFG;
                end else begin
                    r_state   <= S_FCS;
                end
            end
        end
    end

    assign axiod = r_axiod;
    assign axiov = r_axiov;
    assign axiir = r_axiir;
    assign err   = r_err;

endmodule

// File: tb/tb_ether_fcs_append.sv
// Testbench for ether_fcs_append: a default-parameter instance (dut_a) and a
// MIN_NIBBLES=0 instance (dut_c) for the standard CRC check vector. Expected
// output nibbles are queued when a frame is driven and compared by a monitor
// on the falling clock edge whenever axiov is high.
module tb_ether_fcs_append;

    localparam int PRE     = 16;
    localparam int MIN_DEF = 120;
    localparam int IFG     = 24;

    logic       clk;
    logic       rst;
    logic [3:0] a_id, c_id, a_od, c_od;
    logic       a_iv, c_iv, a_ir, c_ir, a_ov, c_ov, a_err, c_err;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_a[$];
    logic [3:0] exp_c[$];
    logic [3:0] stim_q[$];
    logic [3:0] body_q[$];
    logic [3:0] exp_nib_a, exp_nib_c;
    int a_run = 0, c_run = 0, a_last_run = 0, c_last_run = 0;

    ether_fcs_append dut_a (
        .clk(clk), .rst(rst), .axiid(a_id), .axiiv(a_iv),
        .axiir(a_ir), .axiod(a_od), .axiov(a_ov), .err(a_err)
    );

    ether_fcs_append #(.MIN_NIBBLES(0)) dut_c (
        .clk(clk), .rst(rst), .axiid(c_id), .axiiv(c_iv),
        .axiir(c_ir), .axiod(c_od), .axiov(c_ov), .err(c_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: pop one expected nibble per valid output cycle.
    always @(negedge clk) begin
        if (a_ov === 1'b1) begin
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_output: axiod=%h axiov=1, required axiov=0", a_od);
            end else begin
                exp_nib_a = exp_a.pop_front();
                if (a_od !== exp_nib_a) begin
                    errors++;
                    $display("FAIL a_axiod: got %h, required %h", a_od, exp_nib_a);
                end
            end
            a_run++;
        end else begin
            if (a_run != 0) a_last_run = a_run;
            a_run = 0;
        end
        if (c_ov === 1'b1) begin
            checks++;
            if (exp_c.size() == 0) begin
                errors++;
                $display("FAIL c_unexpected_output: axiod=%h axiov=1, required axiov=0", c_od);
            end else begin
                exp_nib_c = exp_c.pop_front();
                if (c_od !== exp_nib_c) begin
                    errors++;
                    $display("FAIL c_axiod: got %h, required %h", c_od, exp_nib_c);
                end
            end
            c_run++;
        end else begin
            if (c_run != 0) c_last_run = c_run;
            c_run = 0;
        end
    end

    // Byte-wise software CRC32 over body_q (pairs of nibbles, low first).
    function automatic logic [31:0] ref_crc();
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i + 1 < body_q.size(); i += 2) begin
            b = {body_q[i+1], body_q[i]};
            c = c ^ {24'h0, b};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic push_exp(input bit sel, input logic [3:0] d);
        if (sel) exp_c.push_back(d);
        else     exp_a.push_back(d);
    endtask

    task automatic drive_nibble(input bit sel, input logic [3:0] d);
        if (sel) begin c_id = d; c_iv = 1'b1; end
        else     begin a_id = d; a_iv = 1'b1; end
        @(posedge clk); #1;
    endtask

    task automatic release_bus(input bit sel);
        if (sel) begin c_iv = 1'b0; c_id = 4'h0; end
        else     begin a_iv = 1'b0; a_id = 4'h0; end
    endtask

    task automatic wait_ready(input bit sel);
        int n;
        n = 0;
        while ((sel ? c_ir : a_ir) !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if ((sel ? c_ir : a_ir) !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready: axiir=%b after %0d cycles, required 1", sel ? c_ir : a_ir, n);
        end
    endtask

    task automatic wait_drain(input bit sel, input string tag);
        int n;
        n = 0;
        while ((sel ? exp_c.size() : exp_a.size()) != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if ((sel ? exp_c.size() : exp_a.size()) != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected nibbles never appeared, required 0 left",
                     tag, sel ? exp_c.size() : exp_a.size());
            if (sel) exp_c.delete(); else exp_a.delete();
        end
    endtask

    // Counts idle output cycles after a frame until axiir is seen high again.
    task automatic measure_gap(input bit sel, input string tag);
        int gap;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while ((sel ? c_ir : a_ir) !== 1'b1 && gap < 100);
        checks++;
        if (gap != IFG) begin
            errors++;
            $display("FAIL %s_gap: got %0d idle cycles before axiir=1, required %0d", tag, gap, IFG);
        end
    endtask

    task automatic check_run(input bit sel, input string tag, input int req);
        int got;
        got = sel ? c_last_run : a_last_run;
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s_run: got %0d consecutive valid cycles, required %0d", tag, got, req);
        end
    endtask

    // Queues the expected output of a whole frame built from stim_q, then drives it.
    task automatic send_frame(input bit sel, input bit use_req, input logic [31:0] req,
                              input int n_fcs, output logic [31:0] fcs);
        int min_n;
        min_n  = sel ? 0 : MIN_DEF;
        body_q = stim_q;
        while (body_q.size() < min_n) body_q.push_back(4'h0);
        fcs = use_req ? req : ref_crc();
        for (int i = 0; i < PRE - 1; i++) push_exp(sel, 4'h5);
        push_exp(sel, 4'hD);
        foreach (body_q[i]) push_exp(sel, body_q[i]);
        for (int k = 0; k < n_fcs; k++) push_exp(sel, fcs[4*k +: 4]);
        wait_ready(sel);
        for (int i = 0; i < PRE - 1; i++) drive_nibble(sel, 4'h5);
        drive_nibble(sel, 4'hD);
        foreach (stim_q[i]) drive_nibble(sel, stim_q[i]);
        release_bus(sel);
    endtask

    task automatic fill_random(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(4'($urandom_range(0, 15)));
    endtask

    task automatic check_idle_outputs(input string tag);
        checks += 8;
        if (a_ov !== 1'b0)   begin errors++; $display("FAIL %s_a_axiov: got %b, required 0", tag, a_ov); end
        if (a_od !== 4'h0)   begin errors++; $display("FAIL %s_a_axiod: got %h, required 0", tag, a_od); end
        if (a_err !== 1'b0)  begin errors++; $display("FAIL %s_a_err: got %b, required 0", tag, a_err); end
        if (a_ir !== 1'b1)   begin errors++; $display("FAIL %s_a_axiir: got %b, required 1", tag, a_ir); end
        if (c_ov !== 1'b0)   begin errors++; $display("FAIL %s_c_axiov: got %b, required 0", tag, c_ov); end
        if (c_od !== 4'h0)   begin errors++; $display("FAIL %s_c_axiod: got %h, required 0", tag, c_od); end
        if (c_err !== 1'b0)  begin errors++; $display("FAIL %s_c_err: got %b, required 0", tag, c_err); end
        if (c_ir !== 1'b1)   begin errors++; $display("FAIL %s_c_axiir: got %b, required 1", tag, c_ir); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("after_reset");
    endtask

    task automatic test_crc_vector();
        logic [31:0] fcs;
        stim_q.delete();
        for (int b = 1; b <= 9; b++) begin
            stim_q.push_back(4'(b));
            stim_q.push_back(4'h3);
        end
        send_frame(1'b1, 1'b1, 32'hCBF43926, 8, fcs);
        wait_drain(1'b1, "crc_vector");
        measure_gap(1'b1, "crc_vector");
        check_run(1'b1, "crc_vector", PRE + 18 + 8);
    endtask

    task automatic test_padding();
        logic [31:0] fcs;
        fill_random(48);
        send_frame(1'b0, 1'b0, 32'h0, 8, fcs);
        wait_drain(1'b0, "padding");
        measure_gap(1'b0, "padding");
        check_run(1'b0, "padding", 144);
    endtask

    task automatic test_preamble_abort();
        wait_ready(1'b0);
        for (int i = 0; i < 5; i++) push_exp(1'b0, 4'h5);
        for (int i = 0; i < 5; i++) drive_nibble(1'b0, 4'h5);
        release_bus(1'b0);
        wait_drain(1'b0, "abort");
        measure_gap(1'b0, "abort");
        check_run(1'b0, "abort", 5);
    endtask

    task automatic test_back_to_back();
        logic [31:0] fcs;
        int n;
        fill_random(40);
        send_frame(1'b0, 1'b0, 32'h0, 8, fcs);
        wait_drain(1'b0, "b2b_first");
        repeat (10) @(posedge clk);
        #1;
        a_id = 4'h5;
        a_iv = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            checks++;
            if (a_err !== 1'b1) begin
                errors++;
                $display("FAIL b2b_err_pulse: got err=%b in held cycle %0d, required 1", a_err, n);
            end
        end while (a_ir !== 1'b1 && n < 100);
        checks++;
        if (n != IFG - 11) begin
            errors++;
            $display("FAIL b2b_err_cycles: got %0d err cycles, required %0d", n, IFG - 11);
        end
        release_bus(1'b0);
        @(posedge clk); #1;
        checks++;
        if (a_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_err_clear: got err=%b, required 0", a_err);
        end
        fill_random(130);
        send_frame(1'b0, 1'b0, 32'h0, 8, fcs);
        wait_drain(1'b0, "b2b_second");
        measure_gap(1'b0, "b2b_second");
        check_run(1'b0, "b2b_second", PRE + 130 + 8);
    endtask

    task automatic test_reset_mid();
        logic [31:0] fcs;
        fill_random(120);
        send_frame(1'b0, 1'b0, 32'h0, 3, fcs);
        wait_drain(1'b0, "rst_mid");
        #1;
        checks++;
        if (a_ov !== 1'b1 || a_od !== fcs[15:12]) begin
            errors++;
            $display("FAIL rst_mid_fcs3: got axiov=%b axiod=%h, required axiov=1 axiod=%h",
                     a_ov, a_od, fcs[15:12]);
        end
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_mid_asserted");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("rst_mid_released");
        fill_random(60);
        send_frame(1'b0, 1'b0, 32'h0, 8, fcs);
        wait_drain(1'b0, "rst_next");
        measure_gap(1'b0, "rst_next");
        check_run(1'b0, "rst_next", 144);
    endtask

    initial begin
        rst  = 1'b1;
        a_iv = 1'b0; a_id = 4'h0;
        c_iv = 1'b0; c_id = 4'h0;
        test_reset();
        test_crc_vector();
        test_padding();
        test_preamble_abort();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
